// File: rtl/nibble_parity_checker_v_pkg.sv
// parity_pkg_v: shared definitions for the nibble parity checker slice.
//   state_t         - frame FSM encoding (IDLE / ACCUM / DONE)
//   FRAME_LEN_DEF   - default accepted beats per frame
//   CNT_W_DEF       - default beat / error counter width
package parity_pkg_v;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned FRAME_LEN_DEF = 18;
  localparam int unsigned CNT_W_DEF     = 8;

endpackage

// File: rtl/nibble_parity_checker_v_sat_counter.sv
// sat_counter_v: parameterised saturating up-counter.
//   i_clk  - rising-edge clock
//   i_rst  - asynchronous active-high reset (count -> 0)
//   i_clr  - synchronous clear, wins over i_inc
//   i_inc  - increment request; ignored once the count is all ones
//   o_cnt  - current count
module sat_counter_v #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/nibble_parity_checker_v.sv
// nibble_parity_checker_v: checks the parity reported by an XOR4 gate against
// a locally recomputed parity, counts mismatches and folds the expected parity
// across fixed-length frames.
//
// Optional feature: define NIBBLE_PARITY_CHECKER_ODD_EN to expect odd parity
// (exp = ~^nibble) instead of even parity (exp = ^nibble).
//
// Ports:
//   i_clk          - rising-edge clock
//   i_rst          - asynchronous active-high reset
//   i_clear        - synchronous clear of counters, sticky flag and FSM
//   i_valid        - beat offered
//   o_ready        - beat can be accepted this cycle (low only in DONE)
//   i_nibble[3:0]  - data {a,b,c,d}
//   i_f            - parity reported by the gate for i_nibble
//   o_mismatch     - pulse: previous accepted beat had a parity mismatch
//   o_sticky_err   - set on any mismatch, held until reset/clear
//   o_err_cnt      - saturating mismatch count
//   o_frame_valid  - pulse: frame complete
//   o_frame_parity - XOR of expected parities of the last completed frame
module nibble_parity_checker_v
  import parity_pkg_v::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_nibble,
  input  logic             i_f,
  output logic             o_mismatch,
  output logic             o_sticky_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_frame_valid,
  output logic             o_frame_parity
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_acc;
  logic             r_mismatch;
  logic             r_sticky;
  logic             r_frame_parity;

  logic             w_ready;
  logic             w_frame_valid;
  logic             w_accept;
  logic             w_exp;
  logic             w_mis;
  logic             w_last;

`ifdef NIBBLE_PARITY_CHECKER_ODD_EN
  assign w_exp = ~^i_nibble;
`else
  assign w_exp = ^i_nibble;
`endif

  assign w_mis = w_exp ^ i_f;

  // A beat coincident with i_clear is dropped entirely.
  assign w_accept = i_valid & w_ready & ~i_clear;

  assign w_last = (r_state == ST_ACCUM) &&
                  (r_beat_cnt == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ready       = 1'b1;
    w_frame_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (w_accept && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_ready       = 1'b0;
        w_frame_valid = 1'b1;
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_clear) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_beat_cnt     <= '0;
      r_acc          <= 1'b0;
      r_mismatch     <= 1'b0;
      r_sticky       <= 1'b0;
      r_frame_parity <= 1'b0;
    end else if (i_clear) begin
      // Frame parity of the last completed frame survives a clear.
      r_beat_cnt <= '0;
      r_acc      <= 1'b0;
      r_mismatch <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      r_mismatch <= w_accept & w_mis;
      if (w_accept && w_mis) r_sticky <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc      <= w_exp;
            r_beat_cnt <= CNT_W'(1);
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            if (w_last) begin
              r_frame_parity <= r_acc ^ w_exp;
              r_acc          <= 1'b0;
              r_beat_cnt     <= '0;
            end else begin
              r_acc      <= r_acc ^ w_exp;
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_acc      <= 1'b0;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter_v #(
    .W (CNT_W)
  ) u_err_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_clear),
    .i_inc (w_accept & w_mis),
    .o_cnt (o_err_cnt)
  );

  assign o_ready        = w_ready;
  assign o_frame_valid  = w_frame_valid;
  assign o_mismatch     = r_mismatch;
  assign o_sticky_err   = r_sticky;
  assign o_frame_parity = r_frame_parity;

endmodule
